mmcm_drp_sequencer: RTL and testbench

Hardware sequencer that reprograms the progclk MMCM through its DRP port. It sits between the register block and the MMCM primitive. Host software loads a table of (DRP address, keep-mask, data) entries and pulses start. The block then holds the MMCM in reset, performs one read-modify-write per entry, releases reset and waits for lock. It replaces slow per-register host DRP accesses with a single atomic reconfiguration.

---
 rtl/mmcm_drp_sequencer_pkg.sv | 35 +++
 rtl/mmcm_drp_table.sv | 31 +++
 rtl/mmcm_drp_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_mmcm_drp_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_drp_sequencer_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration sequencer.
// Holds the FSM state encoding, error codes, table entry layout and the
// read-modify-write merge used on every DRP register.
package mmcm_drp_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_HOLD,
        ST_FETCH,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_LOCK_WAIT
    } state_e;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_DRDY_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_LOCK_TIMEOUT = 2'd2;

    // Table entry: {drp_addr[6:0], keep_mask[15:0], data[15:0]}
    localparam int unsigned TBL_WIDTH    = 39;
    localparam int unsigned TBL_DATA_LSB = 0;
    localparam int unsigned TBL_MASK_LSB = 16;
    localparam int unsigned TBL_ADDR_LSB = 32;

    // Bits set in keep are taken from the current register value, the rest
    // from the table data.
    function automatic logic [15:0] rmw_merge(input logic [15:0] rd,
                                              input logic [15:0] keep,
                                              input logic [15:0] data);
        return (rd & keep) | (data & ~keep);
    endfunction

endpackage

// File: rtl/mmcm_drp_table.sv
// Reconfiguration table: simple dual-port RAM, synchronous write and
// registered read, no reset on contents (maps to distributed RAM).
// Ports: clk; we/waddr/wdata write port; raddr read address; rdata entry
// read on the previous clock edge.
module mmcm_drp_table
    import mmcm_drp_sequencer_pkg::*;
#(
    parameter int pTABLE_DEPTH = 32,
    localparam int TW = $clog2(pTABLE_DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [TW-1:0]        waddr,
    input  logic [TBL_WIDTH-1:0] wdata,
    input  logic [TW-1:0]        raddr,
    output logic [TBL_WIDTH-1:0] rdata
);

    logic [TBL_WIDTH-1:0] mem_q [pTABLE_DEPTH];
    logic [TBL_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mmcm_drp_sequencer.sv
// MMCM DRP reconfiguration sequencer. Holds the MMCM in reset, applies one
// read-modify-write per table entry through the DRP, releases reset and
// waits for lock.
// Ports: clk_usb/reset_i clock and sync reset; tbl_* table load port;
// num_entries/start launch; busy/done/error/err_code status;
// drp_* DRP master; mmcm_rst/mmcm_locked MMCM control and status.
module mmcm_drp_sequencer
    import mmcm_drp_sequencer_pkg::*;
#(
    parameter int pTABLE_DEPTH  = 32,
    parameter int pRST_CYCLES   = 16,
    parameter int pDRDY_TIMEOUT = 64,
    parameter int pLOCK_TIMEOUT = 65535,
    localparam int TW = $clog2(pTABLE_DEPTH)
) (
    input  logic                 clk_usb,
    input  logic                 reset_i,
    input  logic                 tbl_we,
    input  logic [TW-1:0]        tbl_waddr,
    input  logic [TBL_WIDTH-1:0] tbl_wdata,
    input  logic [TW:0]          num_entries,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [6:0]           drp_addr,
    output logic                 drp_den,
    output logic                 drp_dwe,
    output logic [15:0]          drp_din,
    input  logic [15:0]          drp_dout,
    input  logic                 drp_drdy,
    output logic                 mmcm_rst,
    input  logic                 mmcm_locked
);

    state_e      state_q, state_d;
    logic [TW:0] idx_q, idx_d;
    logic [TW:0] num_q, num_d;
    logic [15:0] cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [6:0]  drp_addr_q, drp_addr_d;
    logic        drp_den_q, drp_den_d;
    logic        drp_dwe_q, drp_dwe_d;
    logic [15:0] drp_din_q, drp_din_d;
    logic        mmcm_rst_q, mmcm_rst_d;

    logic [TBL_WIDTH-1:0] ent;
    logic [6:0]           ent_addr;
    logic [15:0]          ent_keep;
    logic [15:0]          ent_data;

    // Read address follows idx_d so the entry is already on the table
    // output while in FETCH; idx is stable for the rest of the entry.
    mmcm_drp_table #(
        .pTABLE_DEPTH(pTABLE_DEPTH)
    ) u_table (
        .clk   (clk_usb),
        .we    (tbl_we),
        .waddr (tbl_waddr),
        .wdata (tbl_wdata),
        .raddr (idx_d[TW-1:0]),
        .rdata (ent)
    );

    assign ent_addr = ent[TBL_ADDR_LSB +: 7];
    assign ent_keep = ent[TBL_MASK_LSB +: 16];
    assign ent_data = ent[TBL_DATA_LSB +: 16];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        num_d      = num_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;
        drp_addr_d = drp_addr_q;
        drp_den_d  = 1'b0;
        drp_dwe_d  = 1'b0;
        drp_din_d  = drp_din_q;
        mmcm_rst_d = mmcm_rst_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d      = num_entries;
                    idx_d      = '0;
                    cnt_d      = '0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    busy_d     = 1'b1;
                    mmcm_rst_d = 1'b1;
                    state_d    = ST_RST_HOLD;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == 16'(pRST_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (num_q == '0) begin
                        mmcm_rst_d = 1'b0;
                        state_d    = ST_LOCK_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_FETCH: begin
                // Outputs are registered, so den is raised here to appear
                // during RD_REQ.
                drp_addr_d = ent_addr;
                drp_den_d  = 1'b1;
                state_d    = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (drp_drdy) begin
                    drp_din_d = rmw_merge(drp_dout, ent_keep, ent_data);
                    drp_den_d = 1'b1;
                    drp_dwe_d = 1'b1;
                    state_d   = ST_WR_REQ;
                end else if (cnt_q == 16'(pDRDY_TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_DRDY_TIMEOUT;
                    mmcm_rst_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WR_REQ: begin
                cnt_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (drp_drdy) begin
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                    if (idx_d == num_q) begin
                        mmcm_rst_d = 1'b0;
                        state_d    = ST_LOCK_WAIT;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else if (cnt_q == 16'(pDRDY_TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_DRDY_TIMEOUT;
                    mmcm_rst_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LOCK_WAIT: begin
                if (mmcm_locked) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'(pLOCK_TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_LOCK_TIMEOUT;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_usb) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            num_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            drp_addr_q <= '0;
            drp_den_q  <= 1'b0;
            drp_dwe_q  <= 1'b0;
            drp_din_q  <= '0;
            mmcm_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            num_q      <= num_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            drp_addr_q <= drp_addr_d;
            drp_den_q  <= drp_den_d;
            drp_dwe_q  <= drp_dwe_d;
            drp_din_q  <= drp_din_d;
            mmcm_rst_q <= mmcm_rst_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;
    assign drp_addr = drp_addr_q;
    assign drp_den  = drp_den_q;
    assign drp_dwe  = drp_dwe_q;
    assign drp_din  = drp_din_q;
    assign mmcm_rst = mmcm_rst_q;

endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Self-checking bench for mmcm_drp_sequencer: behavioural DRP slave with
// programmable read/write DRDY latency, scoreboard of expected accesses.
module tb_mmcm_drp_sequencer;

    logic        clk_usb = 1'b0;
    logic        reset_i;
    logic        tbl_we;
    logic [4:0]  tbl_waddr;
    logic [38:0] tbl_wdata;
    logic [5:0]  num_entries;
    logic        start;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [6:0]  drp_addr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_din;
    logic [15:0] drp_dout = 16'h0;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked;

    always #5 clk_usb = ~clk_usb;

    mmcm_drp_sequencer #(
        .pTABLE_DEPTH (32),
        .pRST_CYCLES  (16),
        .pDRDY_TIMEOUT(64),
        .pLOCK_TIMEOUT(65535)
    ) dut (
        .clk_usb    (clk_usb),
        .reset_i    (reset_i),
        .tbl_we     (tbl_we),
        .tbl_waddr  (tbl_waddr),
        .tbl_wdata  (tbl_wdata),
        .num_entries(num_entries),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .drp_addr   (drp_addr),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_din    (drp_din),
        .drp_dout   (drp_dout),
        .drp_drdy   (drp_drdy),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] din;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        model_e;
    logic [15:0] drp_mem [128];
    logic [38:0] tbl_shadow [32];
    int          rd_lat = 1;
    int          wr_lat = 1;
    int          model_lat;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    bit          pend = 1'b0;
    int          pcnt = 0;
    logic [15:0] pval = 16'h0;

    // DRP slave: lat <= 0 means never answer.
    always @(negedge clk_usb) begin
        if (done) done_cnt++;
        drp_drdy = 1'b0;
        if (reset_i) pend = 1'b0;
        if (pend) begin
            if (pcnt <= 1) begin
                drp_drdy = 1'b1;
                drp_dout = pval;
                pend     = 1'b0;
            end else begin
                pcnt--;
            end
        end
        if (drp_den) begin
            acc_cnt++;
            check("den_while_outstanding", {31'b0, pend}, 32'd0);
            check("rst_during_access", {31'b0, mmcm_rst}, 32'd1);
            check("busy_during_access", {31'b0, busy}, 32'd1);
            check("access_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                model_e = exp_q.pop_front();
                check("acc_we", {31'b0, drp_dwe}, {31'b0, model_e.we});
                check("acc_addr", {25'b0, drp_addr}, {25'b0, model_e.addr});
                if (model_e.we) check("acc_din", {16'b0, drp_din}, {16'b0, model_e.din});
            end
            if (drp_dwe) begin
                drp_mem[drp_addr] = drp_din;
                pval      = 16'h0;
                model_lat = wr_lat;
            end else begin
                pval      = drp_mem[drp_addr];
                model_lat = rd_lat;
            end
            if (model_lat > 0) begin
                pend = 1'b1;
                pcnt = model_lat;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    task automatic load_entry(input int i, input logic [6:0] a, input logic [15:0] m,
                              input logic [15:0] d);
        tbl_we        = 1'b1;
        tbl_waddr     = i[4:0];
        tbl_wdata     = {a, m, d};
        tbl_shadow[i] = {a, m, d};
        tick(1);
        tbl_we = 1'b0;
    endtask

    // Push the expected read/write pairs, then pulse start.
    task automatic launch(input int n);
        logic [15:0] sh [128];
        logic [6:0]  a;
        logic [15:0] m, d, nv;
        sh = drp_mem;
        for (int i = 0; i < n; i++) begin
            a  = tbl_shadow[i][38:32];
            m  = tbl_shadow[i][31:16];
            d  = tbl_shadow[i][15:0];
            nv = (sh[a] & m) | (d & ~m);
            exp_q.push_back('{1'b0, a, 16'h0});
            exp_q.push_back('{1'b1, a, nv});
            sh[a] = nv;
        end
        num_entries = n[5:0];
        start       = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick(1);
        end
        check(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_error"}, {31'b0, error}, 32'd0);
        check({tag, "_err_code"}, {30'b0, err_code}, 32'd0);
        check({tag, "_den"}, {31'b0, drp_den}, 32'd0);
        check({tag, "_dwe"}, {31'b0, drp_dwe}, 32'd0);
        check({tag, "_addr"}, {25'b0, drp_addr}, 32'd0);
        check({tag, "_din"}, {16'b0, drp_din}, 32'd0);
        check({tag, "_mmcm_rst"}, {31'b0, mmcm_rst}, 32'd0);
    endtask

    int a0, d0, n;

    initial begin
        reset_i     = 1'b1;
        tbl_we      = 1'b0;
        tbl_waddr   = '0;
        tbl_wdata   = '0;
        num_entries = '0;
        start       = 1'b0;
        mmcm_locked = 1'b0;
        for (int i = 0; i < 128; i++) drp_mem[i] = 16'h0000;
        tick(3);
        check_reset_outputs("reset");
        reset_i = 1'b0;
        tick(1);

        // 1 entry, 2-cycle DRDY
        drp_mem[8] = 16'h1FFF;
        rd_lat = 2;
        wr_lat = 2;
        load_entry(0, 7'h08, 16'h1000, 16'h0145);
        a0 = acc_cnt;
        d0 = done_cnt;
        launch(1);
        check("t1_rst_after_start", {31'b0, mmcm_rst}, 32'd1);
        check("t1_busy_after_start", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        check("t1_accesses_left", exp_q.size(), 32'd0);
        tick(5);
        check("t1_rst_released", {31'b0, mmcm_rst}, 32'd0);
        check("t1_busy_lock_wait", {31'b0, busy}, 32'd1);
        check("t1_no_early_done", done_cnt - d0, 32'd0);
        check("t1_written_value", {16'b0, drp_mem[8]}, 32'h1145);
        mmcm_locked = 1'b1;
        wait_finish(20, "t1_finish");
        tick(1);
        check("t1_done_pulses", done_cnt - d0, 32'd1);
        check("t1_access_count", acc_cnt - a0, 32'd2);
        check("t1_error", {31'b0, error}, 32'd0);

        // 3 entries, 1-cycle DRDY, locked already high
        rd_lat = 1;
        wr_lat = 1;
        drp_mem[9]     = 16'h0F0F;
        drp_mem[7'h14] = 16'h3333;
        load_entry(0, 7'h08, 16'hFF00, 16'h1234);
        load_entry(1, 7'h09, 16'h00FF, 16'hABCD);
        load_entry(2, 7'h14, 16'h0000, 16'h5A5A);
        a0 = acc_cnt;
        d0 = done_cnt;
        launch(3);
        wait_finish(300, "t2_finish");
        tick(1);
        check("t2_access_count", acc_cnt - a0, 32'd6);
        check("t2_accesses_left", exp_q.size(), 32'd0);
        check("t2_done_pulses", done_cnt - d0, 32'd1);
        check("t2_reg14", {16'b0, drp_mem[7'h14]}, 32'h5A5A);

        // zero entries: reset pulse only
        a0 = acc_cnt;
        d0 = done_cnt;
        launch(0);
        n = 0;
        for (int i = 0; i < 100 && mmcm_rst; i++) begin
            n++;
            tick(1);
        end
        check("t3_rst_cycles", n, 32'd16);
        wait_finish(20, "t3_finish");
        tick(1);
        check("t3_access_count", acc_cnt - a0, 32'd0);
        check("t3_done_pulses", done_cnt - d0, 32'd1);

        // DRDY never comes
        rd_lat = 0;
        d0 = done_cnt;
        launch(1);
        for (int i = 0; i < 50 && !drp_den; i++) tick(1);
        check("t4_read_issued", {31'b0, drp_den}, 32'd1);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            n++;
            if (error) break;
        end
        check("t4_timeout_cycles", n, 32'd65);
        check("t4_error", {31'b0, error}, 32'd1);
        check("t4_err_code", {30'b0, err_code}, 32'd1);
        check("t4_mmcm_rst", {31'b0, mmcm_rst}, 32'd0);
        check("t4_busy", {31'b0, busy}, 32'd0);
        check("t4_no_write", exp_q.size(), 32'd1);
        exp_q.delete();
        tick(3);
        check("t4_no_done", done_cnt - d0, 32'd0);
        rd_lat = 1;
        launch(1);
        check("t4_error_cleared", {31'b0, error}, 32'd0);
        check("t4_err_code_cleared", {30'b0, err_code}, 32'd0);
        wait_finish(100, "t4_retry_finish");
        tick(1);
        check("t4_retry_done", done_cnt - d0, 32'd1);

        // lock never arrives; extra starts while busy must be ignored
        mmcm_locked = 1'b0;
        a0 = acc_cnt;
        d0 = done_cnt;
        launch(1);
        for (int i = 0; i < 70000; i++) begin
            if (!busy) break;
            start = (i % 5000 == 100);
            tick(1);
        end
        start = 1'b0;
        check("t5_finish", {31'b0, busy}, 32'd0);
        check("t5_error", {31'b0, error}, 32'd1);
        check("t5_err_code", {30'b0, err_code}, 32'd2);
        tick(2);
        check("t5_access_count", acc_cnt - a0, 32'd2);
        check("t5_no_done", done_cnt - d0, 32'd0);

        // reset in WR_WAIT, then rerun from retained table
        mmcm_locked = 1'b1;
        wr_lat = 0;
        launch(1);
        for (int i = 0; i < 100 && !(drp_den && drp_dwe); i++) tick(1);
        check("t6_write_issued", {31'b0, drp_dwe}, 32'd1);
        tick(3);
        reset_i = 1'b1;
        tick(1);
        check_reset_outputs("t6_reset");
        reset_i = 1'b0;
        tick(2);
        wr_lat = 1;
        a0 = acc_cnt;
        d0 = done_cnt;
        launch(1);
        wait_finish(100, "t6_finish");
        tick(1);
        check("t6_access_count", acc_cnt - a0, 32'd2);
        check("t6_accesses_left", exp_q.size(), 32'd0);
        check("t6_done_pulses", done_cnt - d0, 32'd1);
        check("t6_error", {31'b0, error}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
